// File: rtl/switch_stats_collector.sv
// Per-port ingress/egress statistics: accepted, dropped and delivered counters with atomic snapshot and stream-out.
// Latency: live counters show an event 1 cycle later; the first record is valid 2 cycles after an accepted snap_req.
// Backpressure: stream_ready stalls the record stream (id/data held); live counting never stalls.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   valid_in, fifo_full  per-port ingress valid and ingress FIFO full (accept = valid & ~full, drop = valid & full)
//   target_in            per-port target mask, port p at [p*NUM_PORTS +: NUM_PORTS]
//   valid_out            per-port egress valid, one delivered packet per cycle
//   weighted             0: +1 per event, 1: +popcount(mask) for accept/drop
//   snap_req             snapshot request, honoured only when idle; clr_on_snap selects clear-at-capture
//   snap_busy            high from capture until the last record is accepted
//   stream_*             valid/ready record stream, id = port*3 + kind, data = {sat_flag, count}
module switch_stats_collector #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ID_WIDTH  = $clog2(NUM_PORTS*3)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
  input  logic [NUM_PORTS-1:0]           fifo_full,
  input  logic [NUM_PORTS-1:0]           valid_out,
  input  logic                           weighted,
  input  logic                           snap_req,
  input  logic                           clr_on_snap,
  output logic                           snap_busy,
  output logic                           stream_valid,
  input  logic                           stream_ready,
  output logic [ID_WIDTH-1:0]            stream_id,
  output logic [CNT_WIDTH:0]             stream_data,
  output logic                           stream_last
);

  localparam int NUM_CNT = NUM_PORTS * 3;
  localparam int INC_W   = $clog2(NUM_PORTS + 1);
  localparam int SUM_W   = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(NUM_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_STREAM} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_CNT];
  logic [NUM_CNT-1:0]    r_sat;
  logic [CNT_WIDTH-1:0]  r_shd [NUM_CNT];
  logic [NUM_CNT-1:0]    r_shd_sat;
  logic                  r_clr;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [CNT_WIDTH:0]    r_data;

  logic [INC_W-1:0]      w_amt [NUM_PORTS];
  logic [INC_W-1:0]      w_inc [NUM_CNT];
  logic [SUM_W-1:0]      w_raw [NUM_CNT];
  logic [CNT_WIDTH-1:0]  w_sum [NUM_CNT];
  logic [NUM_CNT-1:0]    w_ovf;
  logic [ID_WIDTH-1:0]   w_nxt_id;

  // Per-port increment amount: 1 in packet mode, number of target copies in weighted mode.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_amt[p] = weighted ? INC_W'($countones(target_in[p*NUM_PORTS +: NUM_PORTS])) : INC_W'(1);
    end
  end

  // Counter layout: index p*3+0 accepted, p*3+1 dropped, p*3+2 delivered.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_inc[p*3]     = (valid_in[p] & ~fifo_full[p]) ? w_amt[p] : '0;
      w_inc[p*3 + 1] = (valid_in[p] &  fifo_full[p]) ? w_amt[p] : '0;
      w_inc[p*3 + 2] = INC_W'(valid_out[p]);
    end
  end

  // One spare carry bit is enough: the largest increment is far below CNT_MAX.
  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      w_raw[k] = {1'b0, r_cnt[k]} + SUM_W'(w_inc[k]);
      w_ovf[k] = w_raw[k][CNT_WIDTH];
      w_sum[k] = w_raw[k][CNT_WIDTH] ? CNT_MAX : w_raw[k][CNT_WIDTH-1:0];
    end
  end

  assign w_nxt_id = r_id + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sat     <= '0;
      r_shd_sat <= '0;
      r_clr     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_id      <= '0;
      r_data    <= '0;
      for (int k = 0; k < NUM_CNT; k++) begin
        r_cnt[k] <= '0;
        r_shd[k] <= '0;
      end
    end else begin
      // Live counters: a clearing capture drops everything up to and including
      // the capture cycle (those events land in the shadow copy instead).
      for (int k = 0; k < NUM_CNT; k++) begin
        if (r_state == S_CAPTURE && r_clr) begin
          r_cnt[k] <= '0;
          r_sat[k] <= 1'b0;
        end else begin
          r_cnt[k] <= w_sum[k];
          r_sat[k] <= r_sat[k] | w_ovf[k];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            r_state <= S_CAPTURE;
            r_clr   <= clr_on_snap;
            r_busy  <= 1'b1;
          end
        end

        S_CAPTURE: begin
          for (int k = 0; k < NUM_CNT; k++) begin
            r_shd[k]     <= w_sum[k];
            r_shd_sat[k] <= r_sat[k] | w_ovf[k];
          end
          r_state <= S_STREAM;
          r_valid <= 1'b1;
          r_id    <= '0;
          r_last  <= 1'b0;
          // Record 0 comes straight from the values being captured this cycle.
          r_data  <= {r_sat[0] | w_ovf[0], w_sum[0]};
        end

        S_STREAM: begin
          if (stream_ready) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_id    <= '0;
              r_data  <= '0;
            end else begin
              r_id   <= w_nxt_id;
              r_last <= (w_nxt_id == LAST_ID);
              r_data <= {r_shd_sat[w_nxt_id], r_shd[w_nxt_id]};
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
          r_id    <= '0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign snap_busy    = r_busy;
  assign stream_valid = r_valid;
  assign stream_id    = r_id;
  assign stream_data  = r_data;
  assign stream_last  = r_last;

endmodule

// File: doc/switch_stats_collector.md
Name: switch_stats_collector

Overview:
- Synthesizable per-port traffic statistics block for the N-port switch. It taps each port's ingress valid, target mask and FIFO-full, plus each egress valid.
- Keeps accepted, dropped and delivered counters per port, either in packet mode or in weighted mode (counts per target copy).
- On request, it snapshots all counters atomically and streams them out over a valid/ready interface.
- It sits beside the switch core and moves ingress/egress accounting into hardware, where it is available on silicon.

Parameters:
- NUM_PORTS, 4, number of switch ports (2..16).
- CNT_WIDTH, 16, counter width in bits (8..32).
- ID_WIDTH, $clog2(NUM_PORTS*3), width of the stream record index.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active high.
- valid_in  input  NUM_PORTS  per-port ingress valid.
- target_in  input  NUM_PORTS*NUM_PORTS  per-port target mask. Port p occupies bits [p*NUM_PORTS +: NUM_PORTS].
- fifo_full  input  NUM_PORTS  per-port ingress FIFO full.
- valid_out  input  NUM_PORTS  per-port egress valid; one delivered packet per cycle.
- weighted  input  1  0 = packet mode, 1 = weighted mode. Sampled every cycle.
- snap_req  input  1  single-cycle snapshot request.
- clr_on_snap  input  1  sampled together with an accepted snap_req; when 1, live counters clear at capture.
- snap_busy  output  1  high from CAPTURE until the last record is accepted.
- stream_valid  output  1  record valid.
- stream_ready  input  1  consumer ready.
- stream_id  output  ID_WIDTH  record index = port*3 + kind, where kind is 0 = accepted, 1 = dropped, 2 = delivered.
- stream_data  output  CNT_WIDTH+1  {sat_flag, count}.
- stream_last  output  1  high on the final record (id = NUM_PORTS*3-1).

Behaviour:
- Reset: all live counters, shadow counters and sat flags are 0. State is IDLE. snap_busy, stream_valid and stream_last are 0; stream_id and stream_data are 0. Reset overrides everything, including mid-stream; any record in flight is discarded.
- Ingress classification per port p, each cycle:
  - accept = valid_in[p] & ~fifo_full[p].
  - drop = valid_in[p] & fifo_full[p].
- Increment amount:
  - Packet mode: +1.
  - Weighted mode: +popcount(target mask of port p), in the range 0..NUM_PORTS. A zero mask adds 0.
- Delivered counter: +1 per cycle with valid_out[p], in both modes.
- Live counter update: registered, so it is visible in the cycle after the event.
- Saturation: a counter clamps at 2^CNT_WIDTH-1 and never wraps. Its sticky sat flag sets when the true sum would exceed the max. The flag clears only on reset or on a clearing capture.
- FSM states: IDLE, CAPTURE, STREAM.
  - IDLE -> CAPTURE on snap_req. snap_req in any other state is ignored and is not queued.
  - CAPTURE (exactly 1 cycle):
    - Shadow counters and shadow sat flags take the live values that include this cycle's events.
    - If clr_on_snap was 1: live counters and sat flags take only the next events, i.e. the cycle-after-capture events are counted from 0. No event is lost or double-counted across the boundary.
    - snap_busy = 1.
  - CAPTURE -> STREAM unconditionally. On entry, stream_id = 0 and stream_valid = 1.
  - STREAM handshake: stream_id, stream_data and stream_last are stable while stream_valid & ~stream_ready. A transfer occurs on stream_valid & stream_ready, and stream_id then increments. Records come out in order 0..NUM_PORTS*3-1, one per cycle maximum.
  - STREAM -> IDLE on transfer with stream_last. In that same cycle stream_valid and snap_busy drop to 0 on the next edge. A snap_req in that same cycle is ignored.
- Live counting continues uninterrupted during CAPTURE and STREAM. Streamed values come only from the shadow registers.
- Back-to-back snapshots are possible: the earliest next accepted snap_req is the first cycle snap_busy = 0.
- stream_data outside STREAM: the output is 0.

Test Plan:
- Reset and idle check:
  - Stimulus: NUM_PORTS=4, CNT_WIDTH=16. Assert rst for 10 cycles mid-stream (after record 5 is accepted). Then snap_req with no traffic.
  - Required response: 12 records, all data 0; stream_last only on id 11; snap_busy low 1 cycle after the last transfer.
- Packet mode:
  - Stimulus: port0 sends 5 valid_in with fifo_full=0 and 3 with fifo_full=1, target 4'b0111. port2 valid_out 5 cycles. Then snapshot.
  - Required response: id0=5, id1=3, id8=5; all other records 0.
- Weighted mode:
  - Stimulus: same traffic as the packet-mode case with weighted=1.
  - Required response: id0=15, id1=9. Mask 4'b0000 on port1 leaves id3=0.
- Saturation:
  - Stimulus: CNT_WIDTH=8, weighted=1, port3 target 4'b1111 accepted for 64 cycles.
  - Required response: id9 = {1, 8'hFF}. After a clr_on_snap capture and a second snapshot: {0, 0}.
- Boundary and backpressure:
  - Stimulus: a port0 accept in the CAPTURE cycle and in the following cycle with clr_on_snap=1. stream_ready toggled 1010… and held low 4 cycles at id6.
  - Required response:
    - First snapshot includes the CAPTURE-cycle event; the second snapshot shows id0=1.
    - id and data are held stable during the stall; no record is skipped or duplicated.
- Ignored request:
  - Stimulus: snap_req pulsed during STREAM.
  - Required response: no second capture; IDLE is reached after 12 transfers.
